// File: rtl/knn_sched_if.sv
// Scheduler bus bundle: two requesters, bank load port, engine port and response port.
// The slave modport is the scheduler; the master modport is its environment.
interface knn_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_query;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_query;

  logic        wr_en;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;

  logic [63:0] eng_query;
  logic [63:0] eng_search_0;
  logic [63:0] eng_search_1;
  logic [63:0] eng_search_2;
  logic [63:0] eng_search_3;
  logic [63:0] eng_search_4;
  logic [63:0] eng_search_5;
  logic [63:0] eng_search_6;
  logic [63:0] eng_search_7;
  logic        eng_in_valid;
  logic [2:0]  eng_addr_1st;
  logic [2:0]  eng_addr_2nd;
  logic        eng_out_valid;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [2:0]  resp_addr_1st;
  logic [2:0]  resp_addr_2nd;
  logic        resp_err;
  logic        busy;

  modport slave (
    input  req0_valid, req0_query, req1_valid, req1_query,
    input  wr_en, wr_addr, wr_data,
    input  eng_addr_1st, eng_addr_2nd, eng_out_valid,
    input  resp_ready,
    output req0_ready, req1_ready, wr_ready,
    output eng_query, eng_search_0, eng_search_1, eng_search_2, eng_search_3,
    output eng_search_4, eng_search_5, eng_search_6, eng_search_7, eng_in_valid,
    output resp_valid, resp_id, resp_addr_1st, resp_addr_2nd, resp_err, busy
  );

  modport master (
    output req0_valid, req0_query, req1_valid, req1_query,
    output wr_en, wr_addr, wr_data,
    output eng_addr_1st, eng_addr_2nd, eng_out_valid,
    output resp_ready,
    input  req0_ready, req1_ready, wr_ready,
    input  eng_query, eng_search_0, eng_search_1, eng_search_2, eng_search_3,
    input  eng_search_4, eng_search_5, eng_search_6, eng_search_7, eng_in_valid,
    input  resp_valid, resp_id, resp_addr_1st, resp_addr_2nd, resp_err, busy
  );
endinterface

// File: rtl/knn_sched.sv
// Round-robin KNN query scheduler: grant->ISSUE->WAIT->RESP, 4 cycles grant-to-grant with a 1-cycle engine.
// Requesters stall until the bank is fully loaded and no write is pending; the response holds until resp_ready.
module knn_sched #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  knn_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0][63:0] bank;
  logic [7:0]       loaded;
  logic [63:0]      qreg;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             rid;
  logic [2:0]       raddr_1st;
  logic [2:0]       raddr_2nd;
  logic             rerr;

  logic grant;
  logic winner;
  logic wr_acc;
  logic timeout_hit;

  // A pending write always beats a grant so the bank never changes under a live query.
  always_comb begin
    winner      = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    grant       = (state == IDLE) && (&loaded) && (bus.req0_valid || bus.req1_valid) && !bus.wr_en;
    wr_acc      = bus.wr_en && bus.wr_ready;
    timeout_hit = (cnt == 4'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.eng_out_valid || timeout_hit) state_nxt = RESP;
      RESP:  if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wr_ready is gated by rst_n so every output is low while reset is held.
  always_comb begin
    bus.wr_ready     = (state == IDLE) && rst_n;
    bus.req0_ready   = grant && !winner;
    bus.req1_ready   = grant && winner;
    bus.eng_in_valid = (state == ISSUE);
    bus.resp_valid   = (state == RESP);
    bus.busy         = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank       <= '0;
      loaded     <= '0;
      qreg       <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      rid        <= 1'b0;
      raddr_1st  <= '0;
      raddr_2nd  <= '0;
      rerr       <= 1'b0;
    end else begin
      if (wr_acc) begin
        bank[bus.wr_addr]   <= bus.wr_data;
        loaded[bus.wr_addr] <= 1'b1;
      end
      if (grant) begin
        qreg       <= winner ? bus.req1_query : bus.req0_query;
        rid        <= winner;
        last_grant <= winner;
      end
      case (state)
        ISSUE: cnt <= '0;
        WAIT: begin
          if (bus.eng_out_valid) begin
            raddr_1st <= bus.eng_addr_1st;
            raddr_2nd <= bus.eng_addr_2nd;
            rerr      <= 1'b0;
          end else if (timeout_hit) begin
            raddr_1st <= '0;
            raddr_2nd <= '0;
            rerr      <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.eng_query     = qreg;
  assign bus.eng_search_0  = bank[0];
  assign bus.eng_search_1  = bank[1];
  assign bus.eng_search_2  = bank[2];
  assign bus.eng_search_3  = bank[3];
  assign bus.eng_search_4  = bank[4];
  assign bus.eng_search_5  = bank[5];
  assign bus.eng_search_6  = bank[6];
  assign bus.eng_search_7  = bank[7];
  assign bus.resp_id       = rid;
  assign bus.resp_addr_1st = raddr_1st;
  assign bus.resp_addr_2nd = raddr_2nd;
  assign bus.resp_err      = rerr;
endmodule

// File: tb/tb_knn_sched.sv
// Bench for knn_sched: L1-distance engine model, scoreboard of expected responses, vector table plus corner sequences.
module tb_knn_sched;
  localparam int TO = 4;

  typedef struct packed {
    logic       id;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       err;
  } resp_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [63:0] q0;
    logic [63:0] q1;
    logic        exp_id;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  knn_sched_if bus ();
  knn_sched #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_issue = 0;
  int issue_cyc = 0;
  int rise_cyc = -1;
  int n_resp = 0;
  int n_grant = 0;
  int gnt_id[$];
  int gnt_cyc[$];
  resp_t sb[$];
  resp_t last_resp;
  logic prev_rv = 1'b0;
  logic [7:0][63:0] tb_bank = '0;
  logic [63:0] q0 = '0;
  logic [63:0] q1 = '0;
  logic eng_on = 1'b1;
  logic eng_force = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] nearest(input logic [63:0] q, input logic [7:0][63:0] b);
    int d[8];
    logic [2:0] b1;
    logic [2:0] b2;
    for (int k = 0; k < 8; k++) begin
      d[k] = 0;
      for (int n = 0; n < 16; n++) begin
        int a;
        int c;
        a = int'(q[n*4 +: 4]);
        c = int'(b[k][n*4 +: 4]);
        d[k] += (a > c) ? a - c : c - a;
      end
    end
    b1 = 3'd0;
    for (int k = 1; k < 8; k++) if (d[k] < d[b1]) b1 = 3'(k);
    b2 = (b1 == 3'd0) ? 3'd1 : 3'd0;
    for (int k = 0; k < 8; k++) if (3'(k) != b1 && d[k] < d[b2]) b2 = 3'(k);
    return {b1, b2};
  endfunction

  function automatic logic outs_any();
    return |{bus.wr_ready, bus.req0_ready, bus.req1_ready, bus.eng_in_valid, bus.resp_valid, bus.busy,
             bus.resp_id, bus.resp_addr_1st, bus.resp_addr_2nd, bus.resp_err, bus.eng_query,
             bus.eng_search_0, bus.eng_search_1, bus.eng_search_2, bus.eng_search_3,
             bus.eng_search_4, bus.eng_search_5, bus.eng_search_6, bus.eng_search_7};
  endfunction

  always @(posedge clk) cyc++;

  // Engine model: result one cycle after the issue strobe, unless switched off.
  initial begin
    logic       pv;
    logic [5:0] pa;
    pv = 1'b0;
    pa = '0;
    bus.eng_out_valid = 1'b0;
    bus.eng_addr_1st  = '0;
    bus.eng_addr_2nd  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_out_valid = pv | eng_force;
      {bus.eng_addr_1st, bus.eng_addr_2nd} = eng_force ? 6'o55 : pa;
      pv = bus.eng_in_valid && eng_on && rst_n;
      if (bus.eng_in_valid)
        pa = nearest(bus.eng_query, {bus.eng_search_7, bus.eng_search_6, bus.eng_search_5, bus.eng_search_4,
                                     bus.eng_search_3, bus.eng_search_2, bus.eng_search_1, bus.eng_search_0});
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    resp_t e;
    resp_t act;
    logic  id;
    if (rst_n) begin
      if (bus.eng_in_valid) begin
        n_issue++;
        issue_cyc = cyc;
      end
      if (bus.resp_valid && !prev_rv) rise_cyc = cyc;
      prev_rv = bus.resp_valid;
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        id = bus.req1_ready;
        e.id = id;
        if (eng_on) begin
          {e.a1, e.a2} = nearest(id ? q1 : q0, tb_bank);
          e.err = 1'b0;
        end else begin
          e.a1 = '0;
          e.a2 = '0;
          e.err = 1'b1;
        end
        sb.push_back(e);
        gnt_id.push_back(int'(id));
        gnt_cyc.push_back(cyc);
        n_grant++;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        act = {bus.resp_id, bus.resp_addr_1st, bus.resp_addr_2nd, bus.resp_err};
        last_resp = act;
        n_resp++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp_unexpected: got response %0h with no expected entry", act);
        end else begin
          e = sb.pop_front();
          check("resp", 64'(act), 64'(e));
        end
      end
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [63:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    tb_bank[a] = d;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_grant(input int g, input string nm);
    for (int i = 0; i < 20 && n_grant == g; i++) tick();
    check(nm, 64'(n_grant > g), 64'd1);
  endtask

  task automatic wait_resp(input int target, input string nm);
    for (int i = 0; i < 40 && n_resp < target; i++) tick();
    check(nm, 64'(n_resp >= target), 64'd1);
  endtask

  task automatic do_query(input logic [63:0] q);
    int g;
    int r;
    g = n_grant;
    r = n_resp;
    q0 = q;
    bus.req0_query = q;
    bus.req0_valid = 1'b1;
    wait_grant(g, "q_grant");
    bus.req0_valid = 1'b0;
    bus.req0_query = ~q;
    wait_resp(r + 1, "q_resp");
  endtask

  vec_t tbl[7];

  initial begin
    int bad;
    int wrbad;
    int g0;
    int r0;
    resp_t snap;

    tbl[0] = '{1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 64'h0, {16{4'h7}}, 1'b1};
    tbl[2] = '{1'b1, 1'b1, {16{4'h0}}, {16{4'hF}}, 1'b0};
    tbl[3] = '{1'b1, 1'b1, {16{4'h5}}, {16{4'h6}}, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 64'h1122_3344_5566_7788, 64'h4444_4444_0000_0000, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 64'h0, {32'h2222_2222, 32'h6666_6666}, 1'b1};

    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_query = '0;
    bus.req1_query = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 64'(outs_any()), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);

    // Partial bank: requester must wait for the last entry.
    for (int k = 0; k < 7; k++) write(3'(k), {16{4'(k)}});
    q0 = {16{4'h3}};
    bus.req0_query = q0;
    bus.req0_valid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.req0_ready || bus.eng_in_valid) bad++;
    end
    check("notloaded_ready", 64'(bad), 64'd0);
    check("notloaded_issue", 64'(n_issue), 64'd0);
    tick();
    write(3'd7, {16{4'h7}});
    @(negedge clk);
    check("grant_after_load", 64'(bus.req0_ready), 64'd1);
    r0 = n_resp;
    tick();
    bus.req0_valid = 1'b0;
    bus.req0_query = ~q0;
    wait_resp(r0 + 1, "single_resp");
    check("single_issue_once", 64'(n_issue), 64'd1);
    check("single_id", 64'(last_resp.id), 64'd0);
    check("single_a1", 64'(last_resp.a1), 64'd3);
    check("single_a2", 64'(last_resp.a2), 64'd2);
    check("single_err", 64'(last_resp.err), 64'd0);

    foreach (tbl[i]) begin
      g0 = n_grant;
      r0 = n_resp;
      q0 = tbl[i].q0;
      q1 = tbl[i].q1;
      bus.req0_query = q0;
      bus.req1_query = q1;
      bus.req0_valid = tbl[i].v0;
      bus.req1_valid = tbl[i].v1;
      wait_grant(g0, "tbl_grant");
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_query = ~q0;
      bus.req1_query = ~q1;
      wait_resp(r0 + 1, "tbl_resp");
      check("tbl_id", 64'(gnt_id[$]), 64'(tbl[i].exp_id));
      check("tbl_resp_id", 64'(last_resp.id), 64'(tbl[i].exp_id));
    end

    // Round robin with both requesters permanently valid.
    g0 = gnt_id.size();
    r0 = n_resp;
    q0 = {16{4'h2}};
    q1 = {16{4'h6}};
    bus.req0_query = q0;
    bus.req1_query = q1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 40 && gnt_id.size() < g0 + 4; i++) tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_count", 64'(gnt_id.size() >= g0 + 4), 64'd1);
    if (gnt_id.size() >= g0 + 4) begin
      for (int j = 0; j < 4; j++) check("rr_id", 64'(gnt_id[g0+j]), 64'(j % 2));
      for (int j = 1; j < 4; j++) check("rr_gap", 64'(gnt_cyc[g0+j] - gnt_cyc[g0+j-1]), 64'd4);
    end
    wait_resp(r0 + 4, "rr_resp");

    // Engine never answers.
    eng_on = 1'b0;
    do_query({16{4'h5}});
    check("to_latency", 64'(rise_cyc - issue_cyc), 64'd5);
    check("to_err", 64'(last_resp.err), 64'd1);
    check("to_addr", 64'({last_resp.a1, last_resp.a2}), 64'd0);
    eng_on = 1'b1;

    // Backpressure, write during RESP, then write/request collision in IDLE.
    bus.resp_ready = 1'b0;
    g0 = n_grant;
    q0 = {16{4'h4}};
    bus.req0_query = q0;
    bus.req0_valid = 1'b1;
    wait_grant(g0, "bp_grant");
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) tick();
    check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
    snap = {bus.resp_id, bus.resp_addr_1st, bus.resp_addr_2nd, bus.resp_err};
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = {16{4'hF}};
    bad = 0;
    wrbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.resp_valid || {bus.resp_id, bus.resp_addr_1st, bus.resp_addr_2nd, bus.resp_err} != snap) bad++;
      if (bus.wr_ready) wrbad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_wr_ready", 64'(wrbad), 64'd0);
    tick();
    r0 = n_resp;
    q0 = {16{4'hE}};
    bus.req0_query = q0;
    bus.req0_valid = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("coll_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("coll_defer", 64'(bus.req0_ready), 64'd0);
    tick();
    tb_bank[0] = {16{4'hF}};
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("coll_grant", 64'(bus.req0_ready), 64'd1);
    tick();
    bus.req0_valid = 1'b0;
    wait_resp(r0 + 2, "coll_resp");
    check("coll_a1", 64'(last_resp.a1), 64'd0);
    check("coll_a2", 64'(last_resp.a2), 64'd7);

    // Engine result outside WAIT is ignored.
    eng_force = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid || bus.busy) bad++;
    end
    tick();
    eng_force = 1'b0;
    tick();
    check("spurious_ignored", 64'(bad), 64'd0);

    // Reset during WAIT.
    eng_on = 1'b0;
    g0 = n_grant;
    q0 = {16{4'h1}};
    bus.req0_query = q0;
    bus.req0_valid = 1'b1;
    wait_grant(g0, "rst_grant");
    bus.req0_valid = 1'b0;
    g0 = n_issue;
    for (int i = 0; i < 10 && n_issue == g0; i++) tick();
    tick();
    check("rst_in_wait", 64'(bus.busy && !bus.resp_valid && !bus.eng_in_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 64'(outs_any()), 64'd0);
    sb.delete();
    tb_bank = '0;
    eng_on = 1'b1;
    tick();
    rst_n = 1'b1;
    g0 = n_grant;
    r0 = n_resp;
    bus.req0_valid = 1'b1;
    repeat (5) tick();
    check("rst_no_grant", 64'(n_grant - g0), 64'd0);
    check("rst_no_resp", 64'(n_resp - r0), 64'd0);
    for (int k = 0; k < 8; k++) write(3'(k), {16{4'(k)}});
    wait_grant(g0, "reload_grant");
    bus.req0_valid = 1'b0;
    wait_resp(r0 + 1, "reload_resp");
    check("reload_a1", 64'(last_resp.a1), 64'd1);
    check("reload_a2", 64'(last_resp.a2), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end
endmodule
